// File: rtl/icache_nway.sv
// N-way set-associative instruction cache with critical-word-early refill,
// uncached single-word bypass and a one-set-per-cycle invalidate-all walk.
module icache_nway #(
    parameter int unsigned  WAYS       = 2,
    parameter int unsigned  SETS       = 128,
    parameter int unsigned  LINE_BYTES = 32,
    localparam int unsigned IDX_W      = $clog2(SETS),
    localparam int unsigned OFF_W      = $clog2(LINE_BYTES),
    localparam int unsigned TAG_W      = 32 - IDX_W - OFF_W
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             valid,
    input  logic [TAG_W-1:0] tag,
    input  logic [IDX_W-1:0] index,
    input  logic [OFF_W-1:0] offset,
    input  logic             uncached,
    output logic             addr_ok,
    output logic             data_ok,
    output logic [31:0]      rdata_l,
    output logic [31:0]      rdata_h,
    output logic             rdata_h_valid,
    input  logic             inv_req,
    output logic             inv_ack,
    output logic             rd_req,
    output logic [2:0]       rd_type,
    output logic [31:0]      rd_addr,
    input  logic             rd_rdy,
    input  logic             ret_valid,
    input  logic             ret_last,
    input  logic [31:0]      ret_data
);

    localparam int unsigned BEATS  = LINE_BYTES / 4;
    localparam int unsigned CNT_W  = $clog2(BEATS);
    localparam int unsigned WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int unsigned LINE_W = LINE_BYTES * 8;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOOKUP = 3'd1;
    localparam logic [2:0] S_MISS   = 3'd2;
    localparam logic [2:0] S_REFILL = 3'd3;
    localparam logic [2:0] S_INVAL  = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [TAG_W-1:0]  req_tag_q;
    logic [IDX_W-1:0]  req_idx_q;
    logic [OFF_W-1:0]  req_off_q;
    logic              req_unc_q;

    logic [WAYS-1:0]   valid_q [SETS];
    logic [WAY_W-1:0]  rr_q    [SETS];
    logic [TAG_W-1:0]  tag_q   [WAYS][SETS];
    logic [LINE_W-1:0] data_q  [WAYS][SETS];
    logic [31:0]       lbuf_q  [BEATS];
    logic [CNT_W-1:0]  beat_cnt_q;
    logic [IDX_W-1:0]  inv_cnt_q;

    logic              tag_hit, lookup_hit;
    logic [WAY_W-1:0]  hit_way, victim;
    logic [LINE_W-1:0] hit_line, new_line;
    logic [31:0]       lbuf_cur [BEATS];
    logic [CNT_W-1:0]  word, word_nx, need;
    logic              h_ok, refill_last;

    // Word position within the line for the latched request
    always_comb begin
        word    = req_off_q[OFF_W-1:2];
        word_nx = word + CNT_W'(1);
        h_ok    = (word != CNT_W'(BEATS - 1));
        need    = h_ok ? word_nx : word;
    end

    // Tag compare across all ways of the latched set
    always_comb begin
        tag_hit = 1'b0;
        hit_way = '0;
        for (int i = 0; i < int'(WAYS); i++) begin
            if (valid_q[req_idx_q][i] && (tag_q[i][req_idx_q] == req_tag_q)) begin
                tag_hit = 1'b1;
                hit_way = WAY_W'(i);
            end
        end
        lookup_hit = (state_q == S_LOOKUP) && tag_hit && !req_unc_q;
        hit_line   = data_q[hit_way][req_idx_q];
    end

    // Victim: lowest invalid way, else the set's round-robin pointer
    always_comb begin
        victim = rr_q[req_idx_q];
        for (int i = int'(WAYS) - 1; i >= 0; i--) begin
            if (!valid_q[req_idx_q][i]) victim = WAY_W'(i);
        end
    end

    // Line buffer as seen with the current beat forwarded in
    always_comb begin
        for (int b = 0; b < int'(BEATS); b++) begin
            lbuf_cur[b] = (ret_valid && (beat_cnt_q == CNT_W'(b))) ? ret_data : lbuf_q[b];
            new_line[32*b +: 32] = lbuf_cur[b];
        end
        refill_last = (state_q == S_REFILL) && ret_valid && ret_last;
    end

    // Next-state and output decode
    always_comb begin
        state_d       = state_q;
        addr_ok       = 1'b0;
        data_ok       = 1'b0;
        rdata_l       = 32'h0;
        rdata_h       = 32'h0;
        rdata_h_valid = 1'b0;
        inv_ack       = 1'b0;
        rd_req        = 1'b0;
        rd_type       = 3'b000;
        rd_addr       = 32'h0;
        case (state_q)
            S_IDLE: begin
                if (inv_req) begin
                    state_d = S_INVAL;
                end else if (valid) begin
                    addr_ok = 1'b1;
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (lookup_hit) begin
                    data_ok       = 1'b1;
                    rdata_l       = hit_line[{word, 5'b0} +: 32];
                    rdata_h       = h_ok ? hit_line[{word_nx, 5'b0} +: 32] : 32'h0;
                    rdata_h_valid = h_ok;
                    if (valid && !inv_req) begin
                        addr_ok = 1'b1;
                        state_d = S_LOOKUP;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    state_d = S_MISS;
                end
            end
            S_MISS: begin
                rd_req  = 1'b1;
                rd_type = req_unc_q ? 3'b010 : 3'b100;
                rd_addr = req_unc_q ? {req_tag_q, req_idx_q, req_off_q}
                                    : {req_tag_q, req_idx_q, OFF_W'(0)};
                if (rd_rdy) state_d = S_REFILL;
            end
            S_REFILL: begin
                if (ret_valid) begin
                    if (req_unc_q) begin
                        if (ret_last) begin
                            data_ok = 1'b1;
                            rdata_l = ret_data;
                        end
                    end else if (beat_cnt_q == need) begin
                        data_ok       = 1'b1;
                        rdata_l       = lbuf_cur[word];
                        rdata_h       = h_ok ? lbuf_cur[word_nx] : 32'h0;
                        rdata_h_valid = h_ok;
                    end
                    if (ret_last) state_d = S_IDLE;
                end
            end
            S_INVAL: begin
                if (inv_cnt_q == IDX_W'(SETS - 1)) begin
                    inv_ack = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (!resetn) begin
            addr_ok       = 1'b0;
            data_ok       = 1'b0;
            rdata_l       = 32'h0;
            rdata_h       = 32'h0;
            rdata_h_valid = 1'b0;
            inv_ack       = 1'b0;
            rd_req        = 1'b0;
            rd_type       = 3'b000;
            rd_addr       = 32'h0;
        end
    end

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // Latch the request on acceptance
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            req_tag_q <= '0;
            req_idx_q <= '0;
            req_off_q <= '0;
            req_unc_q <= 1'b0;
        end else if (addr_ok) begin
            req_tag_q <= tag;
            req_idx_q <= index;
            req_off_q <= offset;
            req_unc_q <= uncached;
        end
    end

    // Refill line buffer and beat counter
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            beat_cnt_q <= '0;
            for (int b = 0; b < int'(BEATS); b++) lbuf_q[b] <= 32'h0;
        end else if (state_q == S_MISS) begin
            beat_cnt_q <= '0;
        end else if ((state_q == S_REFILL) && ret_valid) begin
            lbuf_q[beat_cnt_q] <= ret_data;
            beat_cnt_q         <= ret_last ? '0 : beat_cnt_q + CNT_W'(1);
        end
    end

    // Valid bits, round-robin pointers and the invalidation walk
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            inv_cnt_q <= '0;
            for (int s = 0; s < int'(SETS); s++) begin
                valid_q[s] <= '0;
                rr_q[s]    <= '0;
            end
        end else if (state_q == S_INVAL) begin
            valid_q[inv_cnt_q] <= '0;
            rr_q[inv_cnt_q]    <= '0;
            inv_cnt_q          <= inv_cnt_q + IDX_W'(1);
        end else if (refill_last && !req_unc_q) begin
            valid_q[req_idx_q][victim] <= 1'b1;
            rr_q[req_idx_q] <= (WAYS == 1) ? '0 : rr_q[req_idx_q] + WAY_W'(1);
        end
    end

    // Tag and data arrays, written once per completed cached refill
    always_ff @(posedge clk) begin
        if (refill_last && !req_unc_q) begin
            tag_q[victim][req_idx_q]  <= req_tag_q;
            data_q[victim][req_idx_q] <= new_line;
        end
    end

endmodule

// File: tb/tb_icache_nway.sv
// Directed bench for icache_nway (WAYS=2, SETS=128, LINE_BYTES=32).
module tb_icache_nway;

    localparam int BEATS = 8;

    logic        clk = 1'b0;
    logic        resetn;
    logic        valid;
    logic [19:0] tag;
    logic [6:0]  index;
    logic [4:0]  offset;
    logic        uncached;
    logic        addr_ok, data_ok, rdata_h_valid, inv_req, inv_ack;
    logic [31:0] rdata_l, rdata_h, rd_addr, ret_data;
    logic        rd_req, rd_rdy, ret_valid, ret_last;
    logic [2:0]  rd_type;

    int n_chk  = 0;
    int n_fail = 0;

    icache_nway #(.WAYS(2), .SETS(128), .LINE_BYTES(32)) dut (
        .clk(clk), .resetn(resetn), .valid(valid), .tag(tag), .index(index),
        .offset(offset), .uncached(uncached), .addr_ok(addr_ok), .data_ok(data_ok),
        .rdata_l(rdata_l), .rdata_h(rdata_h), .rdata_h_valid(rdata_h_valid),
        .inv_req(inv_req), .inv_ack(inv_ack), .rd_req(rd_req), .rd_type(rd_type),
        .rd_addr(rd_addr), .rd_rdy(rd_rdy), .ret_valid(ret_valid),
        .ret_last(ret_last), .ret_data(ret_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        unc;
        logic [31:0] base;   // beat k returns base+k
        logic        hit;
        logic [2:0]  rtype;
        logic [31:0] raddr;
        int          dbeat;  // beat index carrying data_ok on a miss
        logic [31:0] l;
        logic [31:0] h;
        logic        hv;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic [31:0] a, logic u, logic [31:0] b, logic ht,
                                logic [2:0] rt, logic [31:0] ra, int db,
                                logic [31:0] l, logic [31:0] h, logic hv);
        vec_t v;
        v.addr = a; v.unc = u; v.base = b; v.hit = ht; v.rtype = rt;
        v.raddr = ra; v.dbeat = db; v.l = l; v.h = h; v.hv = hv;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, ".addr_ok"}, 32'(addr_ok), 0);
        chk({nm, ".data_ok"}, 32'(data_ok), 0);
        chk({nm, ".rd_req"},  32'(rd_req), 0);
        chk({nm, ".inv_ack"}, 32'(inv_ack), 0);
        chk({nm, ".hvalid"},  32'(rdata_h_valid), 0);
        chk({nm, ".rdata_l"}, rdata_l, 0);
        chk({nm, ".rdata_h"}, rdata_h, 0);
        chk({nm, ".rd_addr"}, rd_addr, 0);
        chk({nm, ".rd_type"}, 32'(rd_type), 0);
    endtask

    // One complete fetch, acting as the bus for misses
    task automatic run_access(input vec_t v, input int id);
        int          nbeats, dok_n, dok_beat;
        logic [31:0] l, h;
        logic        hv;
        string       p;
        p = $sformatf("v%0d", id);
        dok_n = 0; dok_beat = -1; l = 0; h = 0; hv = 0;
        @(negedge clk);
        {tag, index, offset} = v.addr;
        uncached = v.unc;
        valid = 1'b1;
        #1 chk({p, ".addr_ok"}, 32'(addr_ok), 1);
        @(negedge clk);
        valid = 1'b0;
        tag = ~tag;
        uncached = 1'b0;
        #1;
        if (v.hit) begin
            chk({p, ".hit_dok"}, 32'(data_ok), 1);
            chk({p, ".hit_l"},   rdata_l, v.l);
            chk({p, ".hit_h"},   rdata_h, v.h);
            chk({p, ".hit_hv"},  32'(rdata_h_valid), 32'(v.hv));
        end else begin
            chk({p, ".lk_dok"}, 32'(data_ok), 0);
            @(negedge clk); #1;
            chk({p, ".rd_req"},  32'(rd_req), 1);
            chk({p, ".rd_type"}, 32'(rd_type), 32'(v.rtype));
            chk({p, ".rd_addr"}, rd_addr, v.raddr);
            @(negedge clk);
            rd_rdy = 1'b1;
            #1 chk({p, ".rd_hold"}, rd_addr, v.raddr);
            @(negedge clk);
            rd_rdy = 1'b0;
            #1 chk({p, ".rd_drop"}, 32'(rd_req), 0);
            nbeats = v.unc ? 1 : BEATS;
            for (int k = 0; k < nbeats; k++) begin
                ret_valid = 1'b1;
                ret_data  = v.base + 32'(k);
                ret_last  = (k == nbeats - 1);
                #1;
                if (data_ok) begin
                    dok_n++; dok_beat = k;
                    l = rdata_l; h = rdata_h; hv = rdata_h_valid;
                end
                @(negedge clk);
            end
            ret_valid = 1'b0;
            ret_last  = 1'b0;
            chk({p, ".dok_cnt"},  32'(dok_n), 1);
            chk({p, ".dok_beat"}, 32'(dok_beat), 32'(v.dbeat));
            chk({p, ".l"},  l, v.l);
            chk({p, ".h"},  h, v.h);
            chk({p, ".hv"}, 32'(hv), 32'(v.hv));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int ack_n, ack_at, aok_n;

        resetn = 1'b0; valid = 1'b1; {tag, index, offset} = 32'h1C00_0008; uncached = 1'b0;
        inv_req = 1'b0; rd_rdy = 1'b1; ret_valid = 1'b1; ret_last = 1'b1; ret_data = 32'hFFFF_FFFF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1 chk_zero("reset");
        valid = 1'b0; rd_rdy = 1'b0; ret_valid = 1'b0; ret_last = 1'b0;
        @(negedge clk);
        resetn = 1'b1;

        // addr, unc, base, hit, rd_type, rd_addr, dok beat, rdata_l, rdata_h, h_valid
        tbl.push_back(mk(32'h1C00_0008, 0, 32'h0,  0, 3'b100, 32'h1C00_0000, 3, 32'h2, 32'h3, 1));
        tbl.push_back(mk(32'h1C00_0008, 0, 32'h0,  1, 3'b000, 32'h0, 0, 32'h2, 32'h3, 1));
        tbl.push_back(mk(32'h1C00_003C, 0, 32'h100, 0, 3'b100, 32'h1C00_0020, 7, 32'h107, 32'h0, 0));
        tbl.push_back(mk(32'h1C00_001C, 0, 32'h0,  1, 3'b000, 32'h0, 0, 32'h7, 32'h0, 0));
        tbl.push_back(mk(32'h1C00_0000, 0, 32'h0,  1, 3'b000, 32'h0, 0, 32'h0, 32'h1, 1));
        tbl.push_back(mk(32'hBFAF_8000, 1, 32'hDEAD_0000, 0, 3'b010, 32'hBFAF_8000, 0, 32'hDEAD_0000, 32'h0, 0));
        tbl.push_back(mk(32'hBFAF_8000, 1, 32'hBEEF_0000, 0, 3'b010, 32'hBFAF_8000, 0, 32'hBEEF_0000, 32'h0, 0));
        tbl.push_back(mk(32'hBFAF_8014, 1, 32'h77, 0, 3'b010, 32'hBFAF_8014, 0, 32'h77, 32'h0, 0));
        tbl.push_back(mk(32'h1000_00A4, 0, 32'hA00, 0, 3'b100, 32'h1000_00A0, 2, 32'hA01, 32'hA02, 1));
        tbl.push_back(mk(32'h2000_00A4, 0, 32'hB00, 0, 3'b100, 32'h2000_00A0, 2, 32'hB01, 32'hB02, 1));
        tbl.push_back(mk(32'h1000_00A4, 0, 32'h0,  1, 3'b000, 32'h0, 0, 32'hA01, 32'hA02, 1));
        tbl.push_back(mk(32'h2000_00A4, 0, 32'h0,  1, 3'b000, 32'h0, 0, 32'hB01, 32'hB02, 1));
        tbl.push_back(mk(32'h3000_00A4, 0, 32'hC00, 0, 3'b100, 32'h3000_00A0, 2, 32'hC01, 32'hC02, 1));
        tbl.push_back(mk(32'h2000_00A4, 0, 32'h0,  1, 3'b000, 32'h0, 0, 32'hB01, 32'hB02, 1));
        tbl.push_back(mk(32'h3000_00A4, 0, 32'h0,  1, 3'b000, 32'h0, 0, 32'hC01, 32'hC02, 1));
        tbl.push_back(mk(32'h1000_00A4, 0, 32'hA10, 0, 3'b100, 32'h1000_00A0, 2, 32'hA11, 32'hA12, 1));
        tbl.push_back(mk(32'h3000_00A4, 0, 32'h0,  1, 3'b000, 32'h0, 0, 32'hC01, 32'hC02, 1));
        tbl.push_back(mk(32'h2000_00A4, 0, 32'hB10, 0, 3'b100, 32'h2000_00A0, 2, 32'hB11, 32'hB12, 1));
        tbl.push_back(mk(32'h1000_00A4, 0, 32'h0,  1, 3'b000, 32'h0, 0, 32'hA11, 32'hA12, 1));
        tbl.push_back(mk(32'h1C00_0008, 0, 32'h0,  1, 3'b000, 32'h0, 0, 32'h2, 32'h3, 1));
        foreach (tbl[i]) run_access(tbl[i], i);

        // Back-to-back hits with valid held high
        @(negedge clk);
        {tag, index, offset} = 32'h1C00_0008; valid = 1'b1;
        #1 chk("b2b.acc0", 32'(addr_ok), 1);
        @(negedge clk);
        {tag, index, offset} = 32'h1C00_001C;
        #1;
        chk("b2b.dok0", 32'(data_ok), 1);
        chk("b2b.l0",   rdata_l, 32'h2);
        chk("b2b.h0",   rdata_h, 32'h3);
        chk("b2b.acc1", 32'(addr_ok), 1);
        @(negedge clk);
        valid = 1'b0;
        #1;
        chk("b2b.dok1", 32'(data_ok), 1);
        chk("b2b.l1",   rdata_l, 32'h7);
        chk("b2b.hv1",  32'(rdata_h_valid), 0);
        chk("b2b.acc2", 32'(addr_ok), 0);

        // Invalidate-all with a fetch pending: walk takes one cycle per set
        @(negedge clk);
        inv_req = 1'b1; valid = 1'b1; {tag, index, offset} = 32'h1C00_0008;
        #1 chk("inv.acc_blk", 32'(addr_ok), 0);
        ack_n = 0; ack_at = -1; aok_n = 0;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            #1;
            if (addr_ok) aok_n++;
            if (inv_ack) begin
                ack_n++; ack_at = c;
                inv_req = 1'b0; valid = 1'b0;
                break;
            end
        end
        chk("inv.ack_cnt", 32'(ack_n), 1);
        chk("inv.ack_at",  32'(ack_at), 128);
        chk("inv.addr_ok", 32'(aok_n), 0);
        inv_req = 1'b0; valid = 1'b0;
        @(negedge clk);
        #1 chk("inv.ack_pulse", 32'(inv_ack), 0);
        run_access(mk(32'h1C00_0008, 0, 32'h50, 0, 3'b100, 32'h1C00_0000, 3, 32'h52, 32'h53, 1), 100);

        // Reset in the middle of a cached refill
        @(negedge clk);
        {tag, index, offset} = 32'h4000_0000; uncached = 1'b0; valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        @(negedge clk);
        #1 chk("mr.rd_req", 32'(rd_req), 1);
        rd_rdy = 1'b1;
        @(negedge clk);
        rd_rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            ret_valid = 1'b1; ret_data = 32'h400 + 32'(k); ret_last = 1'b0;
            @(negedge clk);
        end
        resetn = 1'b0; ret_data = 32'h403;
        #1 chk_zero("mr.rst0");
        @(negedge clk);
        ret_data = 32'h404;
        #1 chk_zero("mr.rst1");
        @(negedge clk);
        resetn = 1'b1;
        for (int k = 5; k < BEATS; k++) begin
            ret_valid = 1'b1; ret_data = 32'h400 + 32'(k); ret_last = (k == BEATS - 1);
            #1 chk($sformatf("mr.stale%0d", k), 32'(data_ok), 0);
            @(negedge clk);
        end
        ret_valid = 1'b0; ret_last = 1'b0;
        run_access(mk(32'h4000_0000, 0, 32'h410, 0, 3'b100, 32'h4000_0000, 1, 32'h410, 32'h411, 1), 200);
        run_access(mk(32'h1C00_0008, 0, 32'h60, 0, 3'b100, 32'h1C00_0000, 3, 32'h62, 32'h63, 1), 201);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/icache_nway.md
ICACHE_NWAY -- requirements
Module: icache_nway

Interface
REQ-001 SHALL have parameter WAYS, default 2, the associativity; legal values are 1, 2, 4 and 8.
REQ-002 SHALL have parameter SETS, default 128, the number of sets; must be a power of two, at least 2.
REQ-003 SHALL have parameter LINE_BYTES, default 32, the line size; legal values are 16, 32 and 64.
REQ-004 SHALL derive IDX_W = log2(SETS), OFF_W = log2(LINE_BYTES), TAG_W = 32-IDX_W-OFF_W and BEATS = LINE_BYTES/4.
REQ-005 SHALL have ports, in this order:
- clk  in  1  single clock; all state updates on its rising edge.
- resetn  in  1  asynchronous, active-low reset.
- valid  in  1  fetch request.
- tag  in  TAG_W  physical tag.
- index  in  IDX_W  set index.
- offset  in  OFF_W  byte offset.
- uncached  in  1  request bypasses the cache.
- addr_ok  out  1  request accepted this cycle.
- data_ok  out  1  response valid this cycle.
- rdata_l  out  32  word at offset.
- rdata_h  out  32  next word in line.
- rdata_h_valid  out  1  rdata_h is meaningful.
- inv_req  in  1  invalidate-all request, level-held until inv_ack.
- inv_ack  out  1  one-cycle pulse when invalidation completes.
- rd_req  out  1  bus read request.
- rd_type  out  3  3'b010 = single word, 3'b100 = line burst of BEATS words.
- rd_addr  out  32  bus read address.
- rd_rdy  in  1  bus accepts rd_req.
- ret_valid  in  1  return beat valid.
- ret_last  in  1  final beat.
- ret_data  in  32  beat data.

Function
REQ-006 SHALL implement the states IDLE, LOOKUP, MISS, REFILL and INVAL.
REQ-007 SHALL compute addr_ok = valid & !inv_req & (IDLE | (LOOKUP & hit & !uncached_reg)); on addr_ok it latches tag, index, offset and uncached and enters LOOKUP.
REQ-008 SHALL, in LOOKUP, compare the latched tag against all WAYS tag/valid entries read on the accept cycle.
- A hit requires valid & tag-match & !uncached.
- On a hit, data_ok=1 in that same cycle.
- On a hit the next state is LOOKUP if a new request is accepted, otherwise IDLE.
- Back-to-back hits sustain one response per cycle.
REQ-009 SHALL drive the outputs for word index w = offset[OFF_W-1:2] as follows:
- rdata_l = word w of the line.
- rdata_h = word w+1 of the line.
- rdata_h_valid = (w != BEATS-1); rdata_h is 0 when rdata_h_valid = 0.
REQ-010 SHALL move a miss or an uncached request from LOOKUP to MISS, and in MISS:
- assert rd_req;
- drive rd_type = 3'b100 and rd_addr = {tag, index, OFF_W'b0} when cached;
- drive rd_type = 3'b010 and rd_addr = the full byte address when uncached;
- hold rd_req and rd_addr stable until rd_rdy, then enter REFILL with rd_req=0.
REQ-011 SHALL, in REFILL, store each ret_valid beat into line-buffer slot beat_cnt and then increment beat_cnt; beats arrive in ascending word order.
REQ-012 SHALL, for a cached refill, assert data_ok on the first beat at which word w and, if rdata_h_valid, word w+1 are available (critical word early); the current beat is forwarded combinationally.
REQ-013 SHALL, for an uncached read, assert data_ok on ret_last with rdata_l = ret_data and rdata_h_valid = 0; no array update occurs.
REQ-014 SHALL, on ret_last of a cached refill, write the tag, valid=1 and the full line into the victim way of the set, clear beat_cnt and return to IDLE.
REQ-015 SHALL assert data_ok exactly once per accepted request.
REQ-016 SHALL select the victim as follows:
- the lowest-numbered invalid way of the set, if any;
- otherwise the way selected by the per-set round-robin pointer (log2 WAYS bits), which increments modulo WAYS on each refill of that set;
- way 0 always when WAYS = 1.
REQ-017 SHALL leave the replacement state unchanged on a hit.
REQ-018 SHALL, in IDLE, give inv_req priority over valid and enter INVAL.
- It clears the valid bits of one set per cycle, set 0 to SETS-1, over SETS cycles.
- It also resets every round-robin pointer.
- It pulses inv_ack on the cycle it clears set SETS-1, then returns to IDLE.
- addr_ok stays 0 throughout INVAL.
REQ-019 SHALL ignore ret_valid, ret_last and rd_rdy outside MISS and REFILL.
REQ-020 SHALL not let deassertion of valid after acceptance cancel the request.

Reset
REQ-021 SHALL, while resetn=0 (asynchronously), force the following:
- state = IDLE;
- every valid bit, round-robin pointer, beat_cnt and line buffer = 0;
- addr_ok, data_ok, rd_req, inv_ack, rdata_h_valid = 0;
- rdata_l, rdata_h, rd_addr = 0, and rd_type = 3'b000.
REQ-022 SHALL, if reset occurs mid-REFILL, discard the partial line with no array write; leftover beats of the aborted burst are ignored.

Verification (WAYS=2, SETS=128, LINE_BYTES=32)
REQ-023 SHALL cover a cold miss then a hit:
- Fetch 0x1C000008 -> rd_req with rd_type 3'b100, rd_addr 0x1C000000.
- Beats 0x0..0x7 -> data_ok on beat 3 with rdata_l=0x2, rdata_h=0x3.
- Refetch of the same address -> hit, data_ok in the LOOKUP cycle.
REQ-024 SHALL cover the last-word case: offset 0x1C -> data_ok on ret_last, rdata_h_valid=0.
REQ-025 SHALL cover an uncached fetch: 0xBFAF8000 -> rd_type 3'b010, rd_addr 0xBFAF8000, data_ok on ret_last, then a second fetch of the same address misses again.
REQ-026 SHALL cover replacement: three distinct tags mapping to set 5 -> ways 0 and 1 are filled, and the third refill evicts way 0 (pointer 0 -> 1).
REQ-027 SHALL cover invalidation: inv_req after filling -> addr_ok=0 for 128 cycles, inv_ack pulses once, and the previously hit address now misses.
REQ-028 SHALL cover reset during REFILL: resetn low after beat 2 -> all outputs 0 and a subsequent fetch of that line misses.
